// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and sizes for the product accumulator (ACC_SATURATE_EN selects saturation)
package acc_pkg;

    // Width of the unsigned product delivered by the 4x4 multiplier
    localparam int PROD_W = 8;

    // Default accumulator/result width and beat-counter width
    localparam int ACC_W_DEF   = 16;
    localparam int COUNT_W_DEF = 4;

    // Packet FSM: collecting the first beat, collecting the rest, presenting the result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// rtl/acc_sat_add.sv - accumulator plus product adder with carry; wraps, or clamps when ACC_SATURATE_EN is defined
module acc_sat_add
    import acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full;

    // One extra bit catches the carry out of the accumulator width
    always_comb begin
        full  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        carry = full[ACC_W];
`ifdef ACC_SATURATE_EN
        // Clamp at all-ones; once clamped, later additions carry again and keep it there
        sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        sum   = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - per-packet product accumulator with registered result handshake (ACC_SATURATE_EN optional)
module product_accumulator
    import acc_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [COUNT_W-1:0] cnt;
    logic               ovf;
    logic               valid_q;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a     (acc),
        .b     (in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Ready depends on state only so upstream never sees a combinational loop
    always_comb begin
        in_ready = (state != HOLD);
    end

    // Packet FSM: accumulate beats, then hold the registered result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= ACC_W'(in_prod);
                        cnt <= COUNT_W'(1);
                        ovf <= 1'b0;
                        if (in_last) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                        end else begin
                            state   <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= add_sum;
                        cnt <= (cnt == CNT_MAX) ? cnt : cnt + COUNT_W'(1);
                        ovf <= ovf | add_carry;
                        if (in_last) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Result registers double as the running accumulator; they cannot change in HOLD
    always_comb begin
        out_valid = valid_q;
        out_sum   = acc;
        out_count = cnt;
        out_ovf   = ovf;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator with packet-level reference model
module tb_product_accumulator;
    import acc_pkg::*;

    localparam int     ACC_W   = 16;
    localparam int     COUNT_W = 4;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
    localparam int     CNT_MAX = (1 << COUNT_W) - 1;

    typedef struct {
        longint sum;
        int     cnt;
        bit     ovf;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [PROD_W-1:0]  in_prod;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [COUNT_W-1:0] out_count;
    logic               out_ovf;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_cnt = 0;
    bit   rdy_rand = 1'b0;

    product_accumulator #(
        .ACC_W   (ACC_W),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Packet-level reference: plain integer sum, then wrap or clamp, saturating beat count
    function automatic exp_t model(input int prods[$]);
        exp_t   r;
        longint total = 0;
        foreach (prods[i]) total += prods[i];
        r.ovf = (total > ACC_MAX);
`ifdef ACC_SATURATE_EN
        r.sum = r.ovf ? ACC_MAX : total;
`else
        r.sum = total % (ACC_MAX + 1);
`endif
        r.cnt = (prods.size() > CNT_MAX) ? CNT_MAX : prods.size();
        return r;
    endfunction

    // Present one beat at a negedge and return at the negedge after it is taken
    task automatic send_beat(input int p, input bit l);
        int guard = 0;
        in_valid = 1'b1;
        in_prod  = p[PROD_W-1:0];
        in_last  = l;
        while (!in_ready && guard < 500) begin
            stall_cnt++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) fail_now("in_ready_wait");
        @(negedge clk);
    endtask

    task automatic send_packet(input int prods[$], input int gap_max, input bit keep_valid);
        sb.push_back(model(prods));
        foreach (prods[i]) begin
            send_beat(prods[i], i == prods.size() - 1);
            if (gap_max > 0 && !keep_valid) begin
                int gap = $urandom_range(0, gap_max);
                repeat (gap) begin
                    in_valid = 1'b0;
                    in_prod  = PROD_W'($urandom);
                    in_last  = 1'($urandom);
                    @(negedge clk);
                end
            end
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 5000) begin
            guard++;
            @(negedge clk);
        end
        if (sb.size() != 0) fail_now("drain");
    endtask

    // Random consumer backpressure when enabled
    always @(negedge clk) begin
        if (rdy_rand) out_ready = 1'($urandom);
    end

    // Monitor: checks result stability while stalled and pops the scoreboard on each handshake
    bit                 p_valid = 1'b0;
    bit                 p_ready = 1'b0;
    logic [ACC_W-1:0]   p_sum;
    logic [COUNT_W-1:0] p_count;
    logic               p_ovf;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                chk("valid_held", out_valid, 1);
                if (out_valid) begin
                    chk("stable_sum", out_sum, p_sum);
                    chk("stable_count", out_count, p_count);
                    chk("stable_ovf", out_ovf, p_ovf);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    chk("out_sum", out_sum, e.sum);
                    chk("out_count", out_count, e.cnt);
                    chk("out_ovf", out_ovf, e.ovf);
                end
            end
            p_valid = out_valid;
            p_ready = out_ready;
            p_sum   = out_sum;
            p_count = out_count;
            p_ovf   = out_ovf;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Three beats of 225; result appears the cycle after the last beat
        q = '{225, 225, 225};
        sb.push_back(model(q));
        send_beat(225, 0);
        send_beat(225, 0);
        chk("t1_not_yet_valid", out_valid, 0);
        send_beat(225, 1);
        in_valid = 1'b0;
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_sum", out_sum, 675);
        chk("t1_count", out_count, 3);
        out_ready = 1'b1;
        drain();

        // Single-beat packet, then held off for five cycles with beats offered
        out_ready = 1'b0;
        q = '{9};
        send_packet(q, 0, 0);
        chk("t2_in_ready_hold", in_ready, 0);
        chk("t2_sum", out_sum, 9);
        chk("t2_count", out_count, 1);
        repeat (5) begin
            in_valid = 1'b1;
            in_prod  = PROD_W'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            chk("t3_in_ready", in_ready, 0);
            chk("t3_sum", out_sum, 9);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle_valid", out_valid, 0);
        chk("t3_idle_ready", in_ready, 1);
        drain();

        // 300 beats of 225: overflow and saturated counter
        q.delete();
        repeat (300) q.push_back(225);
        send_packet(q, 0, 0);
        drain();

        // Reset mid-packet discards the partial sum
        out_ready = 1'b0;
        send_beat(100, 0);
        send_beat(200, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_sum", out_sum, 0);
        chk("t5_rst_count", out_count, 0);
        chk("t5_rst_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q = '{4, 5};
        send_packet(q, 0, 0);
        out_ready = 1'b1;
        drain();

        // Reset while a result is pending drops it
        out_ready = 1'b0;
        send_beat(7, 1);
        in_valid = 1'b0;
        chk("t5_hold_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_hold_rst_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back packets with in_valid held: one stall per packet boundary
        out_ready = 1'b1;
        stall_cnt = 0;
        for (int p = 0; p < 5; p++) begin
            q.delete();
            repeat ($urandom_range(1, 6)) q.push_back(int'($urandom_range(0, 255)));
            send_packet(q, 0, 1);
        end
        in_valid = 1'b0;
        chk("t6_stalls", stall_cnt, 4);
        drain();

        // Randomized packets with random gaps and random backpressure
        rdy_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            q.delete();
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 300)) : int'($urandom_range(1, 24));
            repeat (len) q.push_back(int'($urandom_range(0, 255)));
            send_packet(q, 3, 0);
        end
        rdy_rand = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
